// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end sitting directly upstream of decode.
//
// Owns the fetch PC, issues instruction-memory requests under a credit limit,
// tracks the address of every in-flight request, buffers returned words in a
// small in-order queue and drives the IF/ID pipeline register. Responses that
// belong to requests issued before a redirect are counted as stale and dropped.
//
// Optional build macro: FETCH_BYPASS_EN. When defined, a non-stale response
// that finds the queue empty (with no StallD and no redirect) is written
// straight into IF/ID, saving one cycle. Credit, ordering and stale handling
// are the same in both builds.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   StallF                     suppress new fetch requests
//   StallD                     hold the IF/ID register
//   PCSrc_E, PCTarget_E        redirect from Execute (overrides StallD)
//   imem_req_valid/ready/addr  fetch request channel
//   imem_rsp_valid/data        in-order response channel, no back-pressure
//   Instr_D, PC_D, PCPlus4_D   IF/ID register contents
//   Valid_D                    IF/ID holds a real instruction
//
// Handshake: a request transfers on a rising edge where imem_req_valid and
// imem_req_ready are both high. imem_req_valid never looks at imem_req_ready,
// and the address stays PC_F until the transfer happens.
module fetch_stage #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            PCSrc_E,
    input  logic [XLEN-1:0] PCTarget_E,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic [31:0]     Instr_D,
    output logic [XLEN-1:0] PC_D,
    output logic [XLEN-1:0] PCPlus4_D,
    output logic            Valid_D
);

    localparam int          PW      = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int          CW      = $clog2(QDEPTH + 1);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [CW:0] CREDITS = (CW + 1)'(QDEPTH);

    logic [XLEN-1:0] pc_f_q, pc_f_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic [CW-1:0]   stale_q, stale_d;
    logic [CW-1:0]   q_cnt_q, q_cnt_d;
    logic [PW-1:0]   pf_wr_q, pf_wr_d, pf_rd_q, pf_rd_d;
    logic [PW-1:0]   q_wr_q, q_wr_d, q_rd_q, q_rd_d;
    logic [XLEN-1:0] pf_mem_q [QDEPTH];   // addresses of in-flight requests
    logic [31:0]     qi_mem_q [QDEPTH];   // queued instruction words
    logic [XLEN-1:0] qp_mem_q [QDEPTH];   // queued instruction PCs

    logic            ifid_valid_q, ifid_valid_d;
    logic [31:0]     ifid_instr_q, ifid_instr_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0] ifid_pc4_q, ifid_pc4_d;

    logic [CW:0]     used;
    logic            req_valid, accept, rsp_live, rsp_stale;
    logic            q_empty, pop, push, bypass;
    logic [XLEN-1:0] rsp_pc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Every in-flight request already owns a queue slot, so the queue can
    // never overflow. Stale requests still hold their credit until they return.
    assign used      = {1'b0, out_cnt_q} + {1'b0, q_cnt_q};
    // rst_n gates the request so nothing is offered while reset is asserted.
    assign req_valid = rst_n && !StallF && !PCSrc_E && (used < CREDITS);
    assign accept    = req_valid && imem_req_ready;
    assign rsp_stale = imem_rsp_valid && (stale_q != '0);
    assign rsp_live  = imem_rsp_valid && (stale_q == '0);
    assign rsp_pc    = pf_mem_q[pf_rd_q];
    assign q_empty   = (q_cnt_q == '0);
    assign pop       = !PCSrc_E && !StallD && !q_empty;
`ifdef FETCH_BYPASS_EN
    assign bypass    = rsp_live && q_empty && !StallD && !PCSrc_E;
`else
    assign bypass    = 1'b0;
`endif
    // A live response arriving with a redirect is dropped along with the flush.
    assign push      = rsp_live && !PCSrc_E && !bypass;

    always_comb begin
        pc_f_d = pc_f_q;
        if (PCSrc_E) begin
            pc_f_d = {PCTarget_E[XLEN-1:2], 2'b00};
        end else if (accept) begin
            pc_f_d = pc_f_q + XLEN'(4);
        end

        out_cnt_d = out_cnt_q + CW'(accept) - CW'(imem_rsp_valid);

        // On redirect every request still in flight after this edge is stale;
        // a response returning this cycle is already consumed.
        stale_d = stale_q;
        if (PCSrc_E) begin
            stale_d = out_cnt_d;
        end else if (rsp_stale) begin
            stale_d = stale_q - CW'(1);
        end

        // The address FIFO is never flushed: stale responses still pop it.
        pf_wr_d = accept ? ptr_inc(pf_wr_q) : pf_wr_q;
        pf_rd_d = imem_rsp_valid ? ptr_inc(pf_rd_q) : pf_rd_q;

        if (PCSrc_E) begin
            q_wr_d  = '0;
            q_rd_d  = '0;
            q_cnt_d = '0;
        end else begin
            q_wr_d  = push ? ptr_inc(q_wr_q) : q_wr_q;
            q_rd_d  = pop ? ptr_inc(q_rd_q) : q_rd_q;
            q_cnt_d = q_cnt_q + CW'(push) - CW'(pop);
        end

        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        if (PCSrc_E) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP;
        end else if (!StallD) begin
            if (pop) begin
                ifid_valid_d = 1'b1;
                ifid_instr_d = qi_mem_q[q_rd_q];
                ifid_pc_d    = qp_mem_q[q_rd_q];
                ifid_pc4_d   = qp_mem_q[q_rd_q] + XLEN'(4);
            end else if (bypass) begin
                ifid_valid_d = 1'b1;
                ifid_instr_d = imem_rsp_data;
                ifid_pc_d    = rsp_pc;
                ifid_pc4_d   = rsp_pc + XLEN'(4);
            end else begin
                // Bubble: PC_D / PCPlus4_D keep their last values.
                ifid_valid_d = 1'b0;
                ifid_instr_d = NOP;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f_q       <= RESET_PC;
            out_cnt_q    <= '0;
            stale_q      <= '0;
            q_cnt_q      <= '0;
            pf_wr_q      <= '0;
            pf_rd_q      <= '0;
            q_wr_q       <= '0;
            q_rd_q       <= '0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
        end else begin
            pc_f_q       <= pc_f_d;
            out_cnt_q    <= out_cnt_d;
            stale_q      <= stale_d;
            q_cnt_q      <= q_cnt_d;
            pf_wr_q      <= pf_wr_d;
            pf_rd_q      <= pf_rd_d;
            q_wr_q       <= q_wr_d;
            q_rd_q       <= q_rd_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
        end
    end

    // Storage arrays carry data only; validity lives in the counters above.
    always_ff @(posedge clk) begin
        if (accept) begin
            pf_mem_q[pf_wr_q] <= pc_f_q;
        end
        if (push) begin
            qi_mem_q[q_wr_q] <= imem_rsp_data;
            qp_mem_q[q_wr_q] <= rsp_pc;
        end
    end

    // A push into a full queue means the credit accounting is broken.
    a_no_q_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && (q_cnt_q == CW'(QDEPTH))));

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = pc_f_q;
    assign Instr_D        = ifid_instr_q;
    assign PC_D           = ifid_pc_q;
    assign PCPlus4_D      = ifid_pc4_q;
    assign Valid_D        = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: self-checking bench for fetch_stage (XLEN=64, QDEPTH=2).
// A behavioural memory answers accepted requests in order after a per-request
// latency; a scoreboard of expected PCs is filled on each accepted request and
// drained whenever decode consumes a valid IF/ID entry.
module tb_fetch_stage;

    localparam int          W   = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic         StallF, StallD, PCSrc_E;
    logic [W-1:0] PCTarget_E;
    logic         imem_req_valid, imem_req_ready;
    logic [W-1:0] imem_req_addr;
    logic         imem_rsp_valid;
    logic [31:0]  imem_rsp_data;
    logic [31:0]  Instr_D;
    logic [W-1:0] PC_D, PCPlus4_D;
    logic         Valid_D;

    always #5 clk = ~clk;

    fetch_stage #(.XLEN(W), .RESET_PC('0), .QDEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .StallF        (StallF),
        .StallD        (StallD),
        .PCSrc_E       (PCSrc_E),
        .PCTarget_E    (PCTarget_E),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .Instr_D       (Instr_D),
        .PC_D          (PC_D),
        .PCPlus4_D     (PCPlus4_D),
        .Valid_D       (Valid_D)
    );

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int cur_lat = 1;
    int first_valid_cyc = -1;

    logic [W-1:0] exp_q[$];          // scoreboard: PCs decode should see, in order
    logic [W-1:0] exp_fetch_pc;      // model of the next fetch address
    logic [W-1:0] last_acc_addr;
    logic         saw_wrap;

    typedef struct {
        logic [W-1:0] addr;
        int           due;
    } mem_req_t;
    mem_req_t mem_q[$];

    typedef struct {
        logic         sd;
        logic         src;
        logic [W-1:0] tgt;
        int           lat;
        logic         rv;
        logic [W-1:0] addr;
        logic         vd;
        logic [W-1:0] pcd;
    } vec_t;
    vec_t vecs[27];

    function automatic logic [31:0] instr_of(input logic [W-1:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_0F0F;
    endfunction

    function automatic vec_t mk(input logic sd, input logic src, input logic [W-1:0] tgt,
                                input int lat, input logic rv, input logic [W-1:0] addr,
                                input logic vd, input logic [W-1:0] pcd);
        vec_t v;
        v.sd = sd; v.src = src; v.tgt = tgt; v.lat = lat;
        v.rv = rv; v.addr = addr; v.vd = vd; v.pcd = pcd;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // ---------------- scoreboard / memory bookkeeping at negedge ----------------
    task automatic observe();
        logic [W-1:0] e;
        if (Valid_D && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (Valid_D && !StallD && !PCSrc_E) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid (cycle %0d): got PC_D %h expected no instruction",
                         cyc, PC_D);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc_d", PC_D, e);
                check("sb_pcplus4_d", PCPlus4_D, e + 64'd4);
                check("sb_instr_d", {32'h0, Instr_D}, {32'h0, instr_of(e)});
            end
        end
        if (PCSrc_E) begin
            exp_q.delete();
            exp_fetch_pc = {PCTarget_E[W-1:2], 2'b00};
        end
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_fetch_pc);
            if (last_acc_addr == 64'hFFFF_FFFF_FFFF_FFFC && exp_fetch_pc == 64'h0) saw_wrap = 1'b1;
            last_acc_addr = exp_fetch_pc;
            exp_q.push_back(exp_fetch_pc);
            mem_q.push_back('{addr: imem_req_addr, due: cyc + cur_lat});
            exp_fetch_pc = exp_fetch_pc + 64'd4;
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic tick(input logic sf, input logic sd, input logic src, input logic [W-1:0] tgt,
                        input logic rdy, input int lat);
        @(posedge clk);
        #1;
        StallF = sf;
        StallD = sd;
        PCSrc_E = src;
        PCTarget_E = tgt;
        imem_req_ready = rdy;
        cur_lat = lat;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        @(negedge clk);
        observe();
        cyc++;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        StallF = 1'b1;
        StallD = 1'b0;
        PCSrc_E = 1'b0;
        PCTarget_E = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        mem_q.delete();
        exp_q.delete();
        exp_fetch_pc = 64'h0;
        last_acc_addr = 64'h0;
        repeat (2) @(negedge clk);
        check("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
        check("rst_valid_d", {63'h0, Valid_D}, 64'h0);
        check("rst_instr_d", {32'h0, Instr_D}, {32'h0, NOP});
        check("rst_pc_d", PC_D, 64'h0);
        check("rst_pcplus4_d", PCPlus4_D, 64'h0);
        rst_n = 1'b1;   // StallF is still high, so the next edge issues nothing
        cyc = 0;
        first_valid_cyc = -1;
    endtask

    task automatic drain_and_check(input string tag);
        logic [W-1:0] held;
        held = exp_fetch_pc;
        for (int i = 0; i < 14; i++) begin
            tick(1'b1, 1'b0, 1'b0, '0, 1'b1, 1);
            check({tag, "_stallf_req_valid"}, {63'h0, imem_req_valid}, 64'h0);
            check({tag, "_stallf_pc_f"}, imem_req_addr, held);
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 64'h0);
        check({tag, "_bubble_valid"}, {63'h0, Valid_D}, 64'h0);
        check({tag, "_bubble_instr"}, {32'h0, Instr_D}, {32'h0, NOP});
    endtask

    // ---------------- test sequence ----------------
    initial begin
        saw_wrap = 1'b0;

        // Cycle-exact trace, memory always ready.
        vecs[0]  = mk(0, 0, 0,       1, 1, 64'h0,    0, 0);
        vecs[1]  = mk(0, 0, 0,       1, 1, 64'h4,    0, 0);
        vecs[2]  = mk(0, 0, 0,       1, 0, 0,        0, 0);
        vecs[3]  = mk(0, 0, 0,       1, 1, 64'h8,    1, 64'h0);
        vecs[4]  = mk(0, 0, 0,       1, 1, 64'hC,    1, 64'h4);
        vecs[5]  = mk(0, 0, 0,       1, 0, 0,        0, 0);
        vecs[6]  = mk(1, 0, 0,       1, 1, 64'h10,   1, 64'h8);
        vecs[7]  = mk(1, 0, 0,       1, 0, 0,        1, 64'h8);
        vecs[8]  = mk(1, 0, 0,       1, 0, 0,        1, 64'h8);
        vecs[9]  = mk(1, 0, 0,       1, 0, 0,        1, 64'h8);
        vecs[10] = mk(1, 0, 0,       1, 0, 0,        1, 64'h8);
        vecs[11] = mk(0, 0, 0,       1, 0, 0,        1, 64'h8);
        vecs[12] = mk(0, 0, 0,       1, 1, 64'h14,   1, 64'hC);
        vecs[13] = mk(0, 0, 0,       4, 1, 64'h18,   1, 64'h10);
        vecs[14] = mk(0, 0, 0,       4, 0, 0,        0, 0);
        vecs[15] = mk(0, 0, 0,       4, 1, 64'h1C,   1, 64'h14);
        vecs[16] = mk(0, 1, 64'h1003, 1, 0, 0,       0, 0);
        vecs[17] = mk(0, 0, 0,       1, 0, 0,        0, 0);
        vecs[18] = mk(0, 0, 0,       1, 1, 64'h1000, 0, 0);
        vecs[19] = mk(0, 0, 0,       1, 0, 0,        0, 0);
        vecs[20] = mk(0, 0, 0,       1, 1, 64'h1004, 0, 0);
        vecs[21] = mk(0, 0, 0,       1, 0, 0,        0, 0);
        vecs[22] = mk(1, 1, 64'h2000, 1, 0, 0,       1, 64'h1000);
        vecs[23] = mk(0, 0, 0,       1, 1, 64'h2000, 0, 0);
        vecs[24] = mk(0, 0, 0,       1, 1, 64'h2004, 0, 0);
        vecs[25] = mk(0, 0, 0,       1, 0, 0,        0, 0);
        vecs[26] = mk(0, 0, 0,       1, 1, 64'h2008, 1, 64'h2000);

        apply_reset();

        for (int i = 0; i < 27; i++) begin
            tick(1'b0, vecs[i].sd, vecs[i].src, vecs[i].tgt, 1'b1, vecs[i].lat);
`ifndef FETCH_BYPASS_EN
            check($sformatf("vec%0d_req_valid", i), {63'h0, imem_req_valid}, {63'h0, vecs[i].rv});
            if (vecs[i].rv) check($sformatf("vec%0d_req_addr", i), imem_req_addr, vecs[i].addr);
            check($sformatf("vec%0d_valid_d", i), {63'h0, Valid_D}, {63'h0, vecs[i].vd});
            if (vecs[i].vd) check($sformatf("vec%0d_pc_d", i), PC_D, vecs[i].pcd);
            else check($sformatf("vec%0d_instr_nop", i), {32'h0, Instr_D}, {32'h0, NOP});
`endif
        end
`ifdef FETCH_BYPASS_EN
        check("first_valid_cycle", 64'(first_valid_cyc), 64'd2);
`else
        check("first_valid_cycle", 64'(first_valid_cyc), 64'd3);
`endif

        // StallF with memory idle: no requests, PC_F frozen, queue drains to bubbles.
        drain_and_check("stallf");

        // Back-to-back redirects with requests still in flight.
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, '0, 1'b1, 3);
        tick(1'b0, 1'b0, 1'b1, 64'h3000, 1'b1, 1);
        tick(1'b0, 1'b0, 1'b1, 64'h4002, 1'b1, 1);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0, '0, 1'b1, 1);
        drain_and_check("b2b");

        // Random ready/latency/stalls around the top of the address space.
        tick(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1);
        for (int i = 0; i < 300; i++) begin
            tick(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
                 (i >= 40) && ($urandom_range(0, 29) == 0),
                 {32'($urandom), 32'($urandom)},
                 ($urandom_range(0, 2) != 0), $urandom_range(1, 3));
        end
        check("addr_wrap_seen", {63'h0, saw_wrap}, 64'h1);
        drain_and_check("random");

        // Reset in the middle of traffic; memory is reset with it.
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, '0, 1'b1, 3);
        apply_reset();
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b0, '0, 1'b1, 1);
`ifdef FETCH_BYPASS_EN
        check("post_reset_first_valid", 64'(first_valid_cyc), 64'd2);
`else
        check("post_reset_first_valid", 64'(first_valid_cyc), 64'd3);
`endif
        drain_and_check("post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the RV64I+Zba pipeline; sits directly upstream of decode.
- Consumes the hazard unit's StallF/StallD and Execute's redirect (PCSrc_E/PCTarget_E); produces the IF/ID pipeline register.
- Owns the PC, a latency-tolerant instruction-memory request/response handshake, a small in-order instruction queue, and stale-response squashing after redirects.

Parameters:
- XLEN, 64, PC/address width.
- RESET_PC, 64'h0000_0000_0000_0000, first fetch address after reset.
- QDEPTH, 2, instruction-queue entries; also the maximum of (outstanding requests + queued entries). Legal range 2..8.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- StallF  in  1  hazard unit: suppress new fetch requests.
- StallD  in  1  hazard unit: hold the IF/ID register.
- PCSrc_E  in  1  Execute: taken branch/jump redirect.
- PCTarget_E  in  XLEN  redirect target.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address (= PC_F).
- imem_rsp_valid  in  1  response valid; in order, at most 1/cycle, ≥1 cycle after acceptance, no back-pressure.
- imem_rsp_data  in  32  instruction word.
- Instr_D  out  32  IF/ID instruction.
- PC_D  out  XLEN  IF/ID PC.
- PCPlus4_D  out  XLEN  IF/ID PC+4.
- Valid_D  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async on rst_n low): PC_F=RESET_PC; outstanding=0; stale=0; queue empty; Valid_D=0; Instr_D=32'h0000_0013 (NOP); PC_D=0; PCPlus4_D=0; imem_req_valid=0.
- Issue rule: imem_req_valid = !StallF && !PCSrc_E && (outstanding + qcount < QDEPTH). Combinational, no dependence on imem_req_ready.
- Handshake: accept when imem_req_valid && imem_req_ready. On accept: PC_F += 4 (mod 2^XLEN, wraps silently), outstanding += 1. Valid must not depend on ready.
- Response:
  - On imem_rsp_valid, outstanding -= 1.
  - If stale>0: discard the data and decrement stale.
  - Else: push {PC, data} into the queue tail. The response PC is tracked by a per-entry PC FIFO of the issued addresses, depth QDEPTH.
- Simultaneous accept and response in the same cycle: outstanding is unchanged.
- IF/ID register:
  - If PCSrc_E: Valid_D=0, Instr_D=NOP. Redirect overrides StallD.
  - Else if StallD: hold all IF/ID outputs.
  - Else if queue non-empty: pop the head into Instr_D/PC_D; PCPlus4_D = PC+4; Valid_D=1.
  - Else: bubble, Valid_D=0, Instr_D=NOP; PC_D and PCPlus4_D hold.
- Redirect (PCSrc_E=1), applied at the same edge:
  - PC_F = {PCTarget_E[XLEN-1:2],2'b00}.
  - Queue flushed.
  - stale = outstanding after this cycle's accept/response accounting, excluding a response consumed this cycle.
  - No request is issued in the redirect cycle.
- Latency: response arriving in cycle N is written to the queue at the end of N and visible on Valid_D/Instr_D in cycle N+2.
- Boundaries:
  - Queue overflow cannot occur by the credit rule; a push into a full queue is an assertion failure.
  - Pop and push on an empty queue in the same cycle: the pop sees old state (bubble), and the push lands.
  - A redirect while a response is arriving in the same cycle: the arriving response counts as stale-consumed; stale excludes it.
  - A back-to-back redirect re-captures stale from the current outstanding count.
  - Reset mid-transaction abandons all state; the memory must also be reset.

Optional Feature:
- FETCH_BYPASS_EN. When defined, a non-stale response arriving while the queue is empty, !StallD and !PCSrc_E is written directly into IF/ID. Latency becomes N+1, and the queue is not written.
- When undefined, all responses pass through the queue (latency N+2).
- Credit, ordering and stale handling are identical in both builds.

Test Plan:
- Reset release, memory always ready, 1-cycle response latency:
  - imem_req_addr = 0x0, 0x4, 0x8…
  - Valid_D first high in cycle 3 (2 with FETCH_BYPASS_EN), with PC_D=0x0 and PCPlus4_D=0x4.
- StallD held high for 5 cycles with queue full:
  - imem_req_valid drops once outstanding+qcount=2.
  - IF/ID holds PC_D=0x8 steady; on release, PC_D advances 0x8→0xC→0x10 with no gaps.
- Redirect with 2 outstanding requests, PCTarget_E=0x1003:
  - Next request address = 0x1000; both old responses are discarded.
  - First Valid_D after the redirect has PC_D=0x1000.
- Redirect while StallD=1:
  - Valid_D=0 and Instr_D=0x00000013 next cycle.
- StallF=1 with memory idle:
  - imem_req_valid=0 throughout; PC_F unchanged; once the queue drains, Valid_D=0 bubbles appear.
- imem_req_ready randomly low, response latency 1–3 cycles, PC_F=0xFFFF_FFFF_FFFF_FFFC:
  - Instruction order is preserved and the next address wraps to 0x0.
  - No queue-overflow assertion fires.
